// File: rtl/gray_stream_checker_if.sv
// Gray stream checker bus: a sample stream in, decode and health status out.
interface gray_stream_checker_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  logic             valid_in;
  logic [WIDTH-1:0] gray_in;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             locked;
  logic             step_err;
  logic             wrap;
  logic [ERR_W-1:0] err_count;

  // Stream source / status consumer side
  modport master (
    output valid_in, gray_in,
    input  bin_out, bin_valid, locked, step_err, wrap, err_count
  );

  // Checker side
  modport slave (
    input  valid_in, gray_in,
    output bin_out, bin_valid, locked, step_err, wrap, err_count
  );
endinterface

// File: rtl/gray_stream_checker.sv
// Gray-code stream checker: decodes each accepted sample and verifies it is
// exactly one count above the previous one. It locks after LOCK_CNT good steps,
// and once locked it flags bad steps (with a saturating count) and reports wraps.
module gray_stream_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  gray_stream_checker_if.slave bus
);

  localparam int GC_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  prev_bin_q, prev_bin_d;
  logic [GC_W-1:0]   good_cnt_q, good_cnt_d;
  logic [WIDTH-1:0]  bin_out_q, bin_out_d;
  logic              bin_valid_q, bin_valid_d;
  logic              step_err_q, step_err_d;
  logic              wrap_q, wrap_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;

  logic [WIDTH-1:0]  dec;
  logic [WIDTH-1:0]  prev_inc;
  logic [GC_W-1:0]   gc_inc;
  logic              is_good;
  logic              is_hold;
  logic              is_bad;
  logic              locked_o;

  // Gray-to-binary decode: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    dec = '0;
    dec[WIDTH-1] = bus.gray_in[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      dec[i] = dec[i+1] ^ bus.gray_in[i];
    end
  end

  // Step classification against the previous accepted value (wrapping +1)
  always_comb begin
    prev_inc = prev_bin_q + {{(WIDTH-1){1'b0}}, 1'b1};
    gc_inc   = good_cnt_q + {{(GC_W-1){1'b0}}, 1'b1};
    is_good  = (dec == prev_inc);
    is_hold  = (dec == prev_bin_q);
    is_bad   = !is_good && !is_hold;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNLOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: only valid samples move the FSM
  always_comb begin
    state_d = state_q;
    if (bus.valid_in) begin
      case (state_q)
        UNLOCKED: state_d = ACQUIRE;
        ACQUIRE:  if (is_good && (gc_inc == GC_W'(LOCK_CNT))) state_d = LOCKED;
        LOCKED:   if (is_bad) state_d = ACQUIRE;
        default:  state_d = UNLOCKED;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    locked_o = (state_q == LOCKED);
  end

  // Datapath next values: decode capture, good-step counter, pulses, error count
  always_comb begin
    prev_bin_d  = prev_bin_q;
    good_cnt_d  = good_cnt_q;
    bin_out_d   = bin_out_q;
    err_count_d = err_count_q;
    bin_valid_d = 1'b0;
    step_err_d  = 1'b0;
    wrap_d      = 1'b0;
    if (bus.valid_in) begin
      prev_bin_d  = dec;
      bin_out_d   = dec;
      bin_valid_d = 1'b1;
      case (state_q)
        UNLOCKED: good_cnt_d = '0;
        ACQUIRE: begin
          if (is_good) begin
            good_cnt_d = gc_inc;
          end else if (is_bad) begin
            good_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (is_good) begin
            wrap_d = (prev_bin_q == {WIDTH{1'b1}}) && (dec == '0);
          end else if (is_bad) begin
            step_err_d = 1'b1;
            good_cnt_d = '0;
            if (err_count_q != {ERR_W{1'b1}}) begin
              err_count_d = err_count_q + {{(ERR_W-1){1'b0}}, 1'b1};
            end
          end
        end
        default: good_cnt_d = '0;
      endcase
    end
  end

  // Datapath registers; reset discards any sample presented in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_bin_q  <= '0;
      good_cnt_q  <= '0;
      bin_out_q   <= '0;
      bin_valid_q <= 1'b0;
      step_err_q  <= 1'b0;
      wrap_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      prev_bin_q  <= prev_bin_d;
      good_cnt_q  <= good_cnt_d;
      bin_out_q   <= bin_out_d;
      bin_valid_q <= bin_valid_d;
      step_err_q  <= step_err_d;
      wrap_q      <= wrap_d;
      err_count_q <= err_count_d;
    end
  end

  // Drive the bus outputs from registered state
  always_comb begin
    bus.bin_out   = bin_out_q;
    bus.bin_valid = bin_valid_q;
    bus.locked    = locked_o;
    bus.step_err  = step_err_q;
    bus.wrap      = wrap_q;
    bus.err_count = err_count_q;
  end

endmodule

// File: doc/gray_stream_checker.md
# gray_stream_checker

Receive-side partner of the Gray-code counter: samples a Gray-coded count stream, decodes it to binary, and checks every accepted sample is exactly one count above the previous one (modulo 2^WIDTH). It acquires lock after a run of good steps, flags and counts step errors once locked, and reports wrap-around. It sits beside the counter in the verification environment and in-design as a health monitor on any Gray-coded bus.

## Interface

- WIDTH, 4, bit width of the Gray code and decoded count (≥2)
- LOCK_CNT, 2, consecutive good steps required to enter LOCKED (≥1)
- ERR_W, 8, width of the saturating error counter

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- valid_in  input  1  gray_in carries a sample this cycle
- gray_in  input  WIDTH  Gray-coded count sample
- bin_out  output  WIDTH  registered binary decode of last accepted sample
- bin_valid  output  1  one-cycle pulse: bin_out updated
- locked  output  1  high while in LOCKED
- step_err  output  1  one-cycle pulse: bad step detected while LOCKED
- wrap  output  1  one-cycle pulse: good step from all-ones to zero while LOCKED
- err_count  output  ERR_W  saturating count of step_err pulses

## Operation

- Decode: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i]. Combinational, registered into bin_out.
- Internal prev_bin (WIDTH) holds last accepted decoded value; good_cnt counts good steps in ACQUIRE.
- Step classification for each valid_in sample with decoded value d:
  - good: d == prev_bin + 1, WIDTH-bit wrapping add (all-ones -> 0 is good).
  - hold: d == prev_bin; neutral, no progress, no error.
  - bad: anything else (backward steps, multi-count jumps, multi-bit Gray changes).
- States:
  - UNLOCKED: first valid sample loads prev_bin, good_cnt := 0, -> ACQUIRE. No classification.
  - ACQUIRE: good -> good_cnt++; when incremented value == LOCK_CNT, -> LOCKED. Bad -> good_cnt := 0, stay; no step_err, no err_count change. Hold -> no change.
  - LOCKED: good -> stay; wrap pulses if prev_bin == all-ones and d == 0. Bad -> step_err pulse, err_count++ (saturates at 2^ERR_W-1), good_cnt := 0, -> ACQUIRE. Hold -> stay.
- Every valid sample (any state) updates prev_bin := d, bin_out := d, pulses bin_valid.
- No valid_in: all state held, pulses low.
- err_count cleared only by rst.

## Timing

- Reset (rst high at clock edge): state UNLOCKED; bin_out = 0, bin_valid = 0, locked = 0, step_err = 0, wrap = 0, err_count = 0, prev_bin = 0, good_cnt = 0. Reset wins over valid_in in the same cycle; that sample is discarded.
- Latency: sample with valid_in at edge N appears as bin_out/bin_valid after edge N, i.e. valid in cycle N+1; step_err, wrap, locked update in the same cycle N+1.
- locked rises in the cycle after the LOCK_CNT-th good step's sample; falls in the same cycle step_err pulses.
- Back-to-back valid samples every cycle fully supported; no backpressure.
- Reset mid-stream: next valid sample restarts acquisition from UNLOCKED; prior prev_bin not used.
- err_count at saturation: step_err still pulses, count holds.

## Test plan

- Reset check: assert rst 2 cycles with valid_in toggling -> all outputs 0, state UNLOCKED, no bin_valid.
- Lock acquire (WIDTH=4, LOCK_CNT=2): Gray 0000,0001,0011 on consecutive cycles -> bin_out 0,1,2; locked rises cycle after third sample; step_err never.
- Wrap: locked, feed Gray 1001 (bin 14), 1000 (bin 15), 0000 -> wrap pulses once with bin_out 0; locked stays 1; err_count 0.
- Bad step when locked: locked at bin 2 (0011), feed 0110 (bin 4) -> step_err pulse, err_count 1, locked 0; then 0111 (5), 0101 (6) -> locked 1 again.
- Hold and gaps: locked at bin 3, feed 0010 twice with valid_in low cycles between -> no step_err, locked stays, bin_valid pulses only on valid cycles.
- Saturation (ERR_W=2): force 5 lock/bad cycles -> err_count stops at 3, step_err pulses on every bad step; rst mid-sequence -> err_count 0, locked 0.
